johnson_phase_decoder: RTL

Downstream consumer of the 4-bit Johnson counter. Samples the counter's 4-bit code and decodes it to a phase index and a one-hot phase strobe. Checks code legality and step-by-step sequencing, and provides a lock indicator plus error reporting for the rest of the timing logic.

---
 rtl/johnson_phase_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/johnson_phase_decoder.sv
// Decodes a sampled 4-bit Johnson code into a phase index and a one-hot strobe.
// It also checks code legality and step sequencing, and reports lock and errors.
module johnson_phase_decoder #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned ERR_W      = 8,
  parameter bit          ALLOW_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       code_in,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic [7:0]       phase_oh,
  output logic             code_valid,
  output logic             wrap,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_step,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic             state_dbg
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t state;
  logic [3:0]  prev_code;
  logic        prev_legal;
  logic        have_prev;
  logic [3:0]  run;

  // Returns {legal, idx}. Illegal codes return idx 0, which callers ignore.
  function automatic logic [3:0] decode(input logic [3:0] c);
    case (c)
      4'b0000: decode = {1'b1, 3'd0};
      4'b0001: decode = {1'b1, 3'd1};
      4'b0011: decode = {1'b1, 3'd2};
      4'b0111: decode = {1'b1, 3'd3};
      4'b1111: decode = {1'b1, 3'd4};
      4'b1110: decode = {1'b1, 3'd5};
      4'b1100: decode = {1'b1, 3'd6};
      4'b1000: decode = {1'b1, 3'd7};
      default: decode = 4'b0000;
    endcase
  endfunction

  logic [3:0] cur_dec;
  logic [3:0] prev_dec;
  logic       cur_legal;
  logic [2:0] cur_idx;
  logic [2:0] prev_idx;
  logic       checked;
  logic       good_step;
  logic       hold_step;
  logic       step_bad;
  logic       any_err;

  always_comb begin
    cur_dec   = decode(code_in);
    prev_dec  = decode(prev_code);
    cur_legal = cur_dec[3];
    cur_idx   = cur_dec[2:0];
    prev_idx  = prev_dec[2:0];
    // Only a legal sample following a legal sample is sequence-checked.
    checked   = have_prev && prev_legal && cur_legal;
    good_step = checked && (cur_idx == prev_idx + 3'd1);
    hold_step = checked && (cur_idx == prev_idx);
    step_bad  = checked && !good_step && !(hold_step && ALLOW_HOLD);
    any_err   = en && (!cur_legal || step_bad);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= '0;
      phase_oh    <= '0;
      code_valid  <= 1'b0;
      wrap        <= 1'b0;
      locked      <= 1'b0;
      err_illegal <= 1'b0;
      err_step    <= 1'b0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
      prev_code   <= '0;
      prev_legal  <= 1'b0;
      have_prev   <= 1'b0;
      run         <= '0;
      state       <= UNLOCKED;
    end else begin
      wrap        <= 1'b0;
      err_illegal <= 1'b0;
      err_step    <= 1'b0;

      if (en) begin
        have_prev  <= 1'b1;
        prev_code  <= code_in;
        prev_legal <= cur_legal;

        if (cur_legal) begin
          phase      <= cur_idx;
          phase_oh   <= 8'd1 << cur_idx;
          code_valid <= 1'b1;
        end else begin
          phase_oh    <= '0;
          code_valid  <= 1'b0;
          err_illegal <= 1'b1;
        end

        err_step <= step_bad;
        wrap     <= good_step && (prev_idx == 3'd7);

        if (any_err) begin
          run    <= '0;
          state  <= UNLOCKED;
          locked <= 1'b0;
        end else if (state == UNLOCKED && good_step) begin
          run <= run + 4'd1;
          if (32'(run) + 32'd1 >= LOCK_CNT) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
      end

      // An error on the same edge as a clear wins and counts as the first error.
      if (any_err) begin
        err_sticky <= 1'b1;
        if (clr_err)
          err_count <= ERR_W'(1);
        else if (err_count != {ERR_W{1'b1}})
          err_count <= err_count + ERR_W'(1);
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end
    end
  end

endmodule
